// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU decoder and the multiply/divide engine.
// Holds the alu_operation codes, opcode/func fields and the engine state type.
package alu_ctrl_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd1;
    localparam logic [OP_W-1:0] OP_OR    = 4'd2;
    localparam logic [OP_W-1:0] OP_AND   = 4'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd7;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd8;
    localparam logic [OP_W-1:0] OP_ADDU  = 4'd9;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd10;
    localparam logic [OP_W-1:0] OP_SUBU  = 4'd11;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd12;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd13;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd14;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd15;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_REGIMM = 6'b000001;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_BNE    = 6'b000101;
    localparam logic [5:0] OPC_BLEZ   = 6'b000110;
    localparam logic [5:0] OPC_BGTZ   = 6'b000111;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;
    localparam logic [5:0] OPC_ADDIU  = 6'b001001;
    localparam logic [5:0] OPC_SLTI   = 6'b001010;
    localparam logic [5:0] OPC_ANDI   = 6'b001100;
    localparam logic [5:0] OPC_ORI    = 6'b001101;
    localparam logic [5:0] OPC_XORI   = 6'b001110;

    localparam logic [5:0] FN_SLL   = 6'b000100;
    localparam logic [5:0] FN_SRL   = 6'b000110;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/func to alu_operation decoder.
// Unlisted R-type funcs and unlisted opcodes both fall back to NOP.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0]      opcode,
    input  logic [5:0]      func,
    output logic [OP_W-1:0] alu_operation
);

    always_comb begin
        alu_operation = OP_NOP;
        if (opcode == OPC_RTYPE) begin
            case (func)
                FN_SLL:   alu_operation = OP_SLL;
                FN_SRL:   alu_operation = OP_SRL;
                FN_XOR:   alu_operation = OP_XOR;
                FN_SUB:   alu_operation = OP_SUB;
                FN_SLT:   alu_operation = OP_SLT;
                FN_SUBU:  alu_operation = OP_SUBU;
                FN_OR:    alu_operation = OP_OR;
                FN_NOR:   alu_operation = OP_NOR;
                FN_ADDU:  alu_operation = OP_ADDU;
                FN_ADD:   alu_operation = OP_ADD;
                FN_AND:   alu_operation = OP_AND;
                FN_MULT:  alu_operation = OP_MULT;
                FN_DIV:   alu_operation = OP_DIV;
                FN_MULTU: alu_operation = OP_MULTU;
                FN_DIVU:  alu_operation = OP_DIVU;
                default:  alu_operation = OP_NOP;
            endcase
        end else begin
            case (opcode)
                OPC_XORI:  alu_operation = OP_XOR;
                OPC_SLTI:  alu_operation = OP_SLT;
                OPC_ADDI:  alu_operation = OP_ADD;
                OPC_ANDI:  alu_operation = OP_AND;
                OPC_ORI:   alu_operation = OP_OR;
                OPC_ADDIU: alu_operation = OP_ADDU;
                // Branches compare by subtraction.
                OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ, OPC_REGIMM:
                           alu_operation = OP_SUB;
                default:   alu_operation = OP_NOP;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control plus iterative radix-2 multiply/divide engine owning HI/LO.
// One shift-add or restoring-divide step per cycle; signs are stripped on entry and restored in FIX.
module alu_ctrl_muldiv #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic              issue_valid,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [OP_W-1:0]   alu_operation,
    output logic              stall,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    import alu_ctrl_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic sgn);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return (sgn && v[DATA_W-1]) ? n : v;
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic neg);
        logic signed [DATA_W-1:0] n;
        n = -signed'(v);
        return neg ? n : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic neg);
        logic signed [2*DATA_W-1:0] n;
        n = -signed'(v);
        return neg ? n : v;
    endfunction

    logic [3:0]        dec_op;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_hi, acc_lo, mcand;
    logic              is_div, neg_a, neg_b, dbz_flag;
    logic              is_long, op_div, op_signed, rt_zero, accept, is_mthi, is_mtlo;
    logic [DATA_W:0]   mul_sum, div_trial;
    logic              div_ok;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    alu_op_decode u_dec (
        .opcode        (opcode),
        .func          (func),
        .alu_operation (dec_op)
    );

    assign alu_operation = OP_W'(dec_op);

    assign is_long   = issue_valid && (dec_op == OP_MULT || dec_op == OP_MULTU ||
                                       dec_op == OP_DIV  || dec_op == OP_DIVU);
    assign op_div    = (dec_op == OP_DIV)  || (dec_op == OP_DIVU);
    assign op_signed = (dec_op == OP_MULT) || (dec_op == OP_DIV);
    assign rt_zero   = (rt_val == '0);
    assign accept    = (state == IDLE) && is_long;
    assign is_mthi   = issue_valid && (opcode == OPC_RTYPE) && (func == FN_MTHI);
    assign is_mtlo   = issue_valid && (opcode == OPC_RTYPE) && (func == FN_MTLO);

    always_comb begin
        state_nxt = state;
        stall     = (state != IDLE);
        case (state)
            IDLE: if (accept) state_nxt = (op_div && rt_zero) ? FIX : BUSY;
            BUSY: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration step: multiplier/quotient bits live in acc_lo, partial product/remainder in acc_hi.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign div_trial = {acc_hi, acc_lo[DATA_W-1]} - {1'b0, mcand};
    assign div_ok    = !div_trial[DATA_W];

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!dbz_flag) begin
            if (is_div) begin
                fix_lo = neg_w(acc_lo, neg_a ^ neg_b);
                fix_hi = neg_w(acc_hi, neg_a);
            end else begin
                {fix_hi, fix_lo} = neg_2w({acc_hi, acc_lo}, neg_a ^ neg_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div   <= op_div;
            neg_a    <= op_signed && rs_val[DATA_W-1];
            neg_b    <= op_signed && rt_val[DATA_W-1];
            dbz_flag <= op_div && rt_zero;
            if (op_div) begin
                mcand  <= mag(rt_val, op_signed);
                acc_hi <= rt_zero ? rs_val : '0;
                acc_lo <= rt_zero ? '1 : mag(rs_val, op_signed);
            end else begin
                mcand  <= mag(rs_val, op_signed);
                acc_hi <= '0;
                acc_lo <= mag(rt_val, op_signed);
            end
        end else if (state == BUSY) begin
            if (is_div) begin
                acc_hi <= div_ok ? div_trial[DATA_W-1:0] : {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
                acc_lo <= {acc_lo[DATA_W-2:0], div_ok};
            end else begin
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && dbz_flag;
            if (accept) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (state == IDLE && is_mthi) begin
                hi <= rs_val;
            end else if (state == IDLE && is_mtlo) begin
                lo <= rs_val;
            end
        end
    end

endmodule
